// File: rtl/regex_stream_scheduler.sv
// regex_stream_scheduler: round-robin sharing of one regex engine among symbol-stream requesters
module regex_stream_scheduler #(
  parameter int NREQ    = 4,
  parameter int ID_W    = 2,
  parameter int POS_W   = 16,
  parameter int ENG_LAT = 1,
  parameter int CLR_CYC = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [2*NREQ-1:0] req_sym,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              eng_clr,
  output logic              eng_i,
  output logic              eng_ic,
  input  logic              eng_o,
  output logic              match_valid,
  output logic [ID_W-1:0]   match_id,
  output logic [POS_W-1:0]  match_pos,
  output logic              rec_done,
  output logic [ID_W-1:0]   rec_id,
  output logic [POS_W-1:0]  rec_matches,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;
  localparam int CW = $clog2(CLR_CYC + ENG_LAT + 2);

  state_t            state, nxt;
  logic [CW-1:0]     cyc;
  logic [ID_W-1:0]   gnt, rr, sel;
  logic [NREQ-1:0]   rot;
  logic              any_v, xfer, hit;
  logic [1:0]        sym;
  logic [POS_W-1:0]  pos, pos_inc, cnt;
  logic [ENG_LAT:0]  tp;
  logic [POS_W-1:0]  pp [ENG_LAT+1];

  assign xfer    = state == STREAM && req_valid[gnt];
  assign sym     = req_sym[{gnt, 1'b0} +: 2];
  assign pos_inc = &pos ? pos : pos + 1'b1;
  assign hit     = eng_o & tp[ENG_LAT];

  // rotate so bit 0 is the rr pointer; lowest set bit wins
  always_comb begin
    rot   = NREQ'({req_valid, req_valid} >> rr);
    sel   = '0;
    any_v = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (rot[k]) begin
        sel   = ID_W'(int'(rr) + k >= NREQ ? int'(rr) + k - NREQ : int'(rr) + k);
        any_v = 1'b1;
      end
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (any_v) nxt = CLEAR;
      CLEAR:   if (cyc == CW'(CLR_CYC - 1)) nxt = STREAM;
      STREAM:  if (xfer && req_last[gnt]) nxt = DRAIN;
      DRAIN:   if (cyc == CW'(ENG_LAT)) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    eng_clr   = state == IDLE || state == CLEAR;
    busy      = state != IDLE;
    req_ready = state == STREAM ? NREQ'(1) << gnt : '0;
  end

  // tp/pp carry {tag,pos} alongside the engine so pp[ENG_LAT] lines up with eng_o
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cyc         <= '0;
      gnt         <= '0;
      rr          <= '0;
      pos         <= '0;
      cnt         <= '0;
      eng_i       <= 1'b0;
      eng_ic      <= 1'b0;
      tp          <= '0;
      for (int j = 0; j <= ENG_LAT; j++) pp[j] <= '0;
      match_valid <= 1'b0;
      match_id    <= '0;
      match_pos   <= '0;
      rec_done    <= 1'b0;
      rec_id      <= '0;
      rec_matches <= '0;
    end else begin
      cyc <= state != nxt ? '0 : cyc + 1'b1;
      if (state == IDLE && any_v) gnt <= sel;
      if (state == DONE) rr <= gnt == ID_W'(NREQ - 1) ? '0 : gnt + 1'b1;
      pos <= state == CLEAR ? '0 : xfer ? pos_inc : pos;
      {eng_i, eng_ic} <= xfer ? sym : 2'b00;
      tp <= {tp[ENG_LAT-1:0], xfer};
      pp[0] <= pos_inc;
      for (int j = 1; j <= ENG_LAT; j++) pp[j] <= pp[j-1];
      match_valid <= hit;
      if (hit) begin
        match_id  <= gnt;
        match_pos <= pp[ENG_LAT];
      end
      cnt <= state == CLEAR ? '0 : hit ? (&cnt ? cnt : cnt + 1'b1) : cnt;
      rec_done <= state == DONE;
      if (state == DONE) begin
        rec_id      <= gnt;
        rec_matches <= cnt;
      end
    end
endmodule

// File: tb/tb_regex_stream_scheduler.sv
// tb_regex_stream_scheduler: directed checks on two schedulers (engine latency 1 and 3)
module tb_regex_stream_scheduler;
  logic clk = 0, reset_n = 0;
  always #5 clk = ~clk;

  logic [3:0]  req_valid_a = 0, req_last_a = 0, req_ready_a;
  logic [3:0]  req_valid_b = 0, req_last_b = 0, req_ready_b;
  logic [7:0]  req_sym_a = 0, req_sym_b = 0;
  logic        eng_clr_a, eng_i_a, eng_ic_a, eng_o_a, match_valid_a, rec_done_a, busy_a;
  logic        eng_clr_b, eng_i_b, eng_ic_b, eng_o_b, match_valid_b, rec_done_b, busy_b;
  logic [1:0]  match_id_a, rec_id_a, match_id_b, rec_id_b;
  logic [15:0] match_pos_a, rec_matches_a, match_pos_b, rec_matches_b;

  regex_stream_scheduler #(.ENG_LAT(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid_a), .req_sym(req_sym_a),
    .req_last(req_last_a), .req_ready(req_ready_a), .eng_clr(eng_clr_a), .eng_i(eng_i_a),
    .eng_ic(eng_ic_a), .eng_o(eng_o_a), .match_valid(match_valid_a), .match_id(match_id_a),
    .match_pos(match_pos_a), .rec_done(rec_done_a), .rec_id(rec_id_a),
    .rec_matches(rec_matches_a), .busy(busy_a));

  regex_stream_scheduler #(.ENG_LAT(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid_b), .req_sym(req_sym_b),
    .req_last(req_last_b), .req_ready(req_ready_b), .eng_clr(eng_clr_b), .eng_i(eng_i_b),
    .eng_ic(eng_ic_b), .eng_o(eng_o_b), .match_valid(match_valid_b), .match_id(match_id_b),
    .match_pos(match_pos_b), .rec_done(rec_done_b), .rec_id(rec_id_b),
    .rec_matches(rec_matches_b), .busy(busy_b));

  // stand-in engines: symbol 2'b11 matches, reported ENG_LAT cycles later
  logic       ea = 0;
  logic [2:0] eb = 0;
  always @(posedge clk) begin
    ea <= !eng_clr_a && eng_i_a && eng_ic_a;
    eb <= eng_clr_b ? 3'b000 : {eb[1:0], eng_i_b & eng_ic_b};
  end
  assign eng_o_a = ea;
  assign eng_o_b = eb[2];

  int mpos_a[$], mid_a[$], rid_a[$], rcnt_a[$];
  int clr_a = 0, ready_bad = 0, cyc = 0;
  logic [3:0] prev_rdy = 0;
  int mb_pos = 0, mb_id = 0, mb_cyc = 0, db_cyc = 0, db_n = 0, db_cnt = 0;
  int checks = 0, errors = 0;

  always begin
    @(posedge clk);
    #2;
    cyc++;
    if (match_valid_a) begin mpos_a.push_back(int'(match_pos_a)); mid_a.push_back(int'(match_id_a)); end
    if (rec_done_a) begin rid_a.push_back(int'(rec_id_a)); rcnt_a.push_back(int'(rec_matches_a)); end
    if (busy_a && eng_clr_a) clr_a++;
    if (!$onehot0(req_ready_a) || (busy_a && req_ready_a != 0 && prev_rdy != 0 && req_ready_a != prev_rdy))
      ready_bad++;
    prev_rdy = !busy_a ? 4'b0 : req_ready_a != 0 ? req_ready_a : prev_rdy;
    if (match_valid_b) begin mb_pos = int'(match_pos_b); mb_id = int'(match_id_b); mb_cyc = cyc; end
    if (rec_done_b) begin db_n++; db_cyc = cyc; db_cnt = int'(rec_matches_b); end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // call at a negedge; returns at the negedge after the symbol was accepted
  task automatic send(input bit b, input int r, input logic [1:0] s, input bit last);
    int k = 0;
    if (b) begin req_valid_b[r] = 1; req_sym_b[2*r +: 2] = s; req_last_b[r] = last; end
    else begin req_valid_a[r] = 1; req_sym_a[2*r +: 2] = s; req_last_a[r] = last; end
    while (!(b ? req_ready_b[r] : req_ready_a[r]) && k < 100) begin @(negedge clk); k++; end
    chk("send_wait", 32'(k < 100), 1);
    @(negedge clk);
    if (b) begin req_valid_b[r] = 0; req_last_b[r] = 0; end
    else begin req_valid_a[r] = 0; req_last_a[r] = 0; end
  endtask

  task automatic wait_rec(input int n);
    int k = 0;
    while (rid_a.size() < n && k < 500) begin @(negedge clk); k++; end
    chk("rec_wait", rid_a.size(), n);
  endtask

  int bm, br, k;
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_eng_clr", eng_clr_a, 1);
    chk("rst_ready", req_ready_a, 0);
    chk("rst_busy", {busy_a, busy_b}, 0);
    chk("rst_eng_sym", {eng_i_a, eng_ic_a}, 0);
    chk("rst_pulses", {match_valid_a, rec_done_a}, 0);
    chk("rst_rec", {rec_id_a, rec_matches_a}, 0);
    chk("rst_match", {match_id_a, match_pos_a}, 0);
    reset_n = 1;

    // all requesters hold one-symbol records: grants rotate 0,1,2,3,0
    br = rid_a.size();
    req_sym_a = 8'h55; req_last_a = 4'hF; req_valid_a = 4'hF;
    k = 0;
    while (rid_a.size() - br < 5 && k < 300) begin @(negedge clk); k++; end
    req_valid_a = 0; req_last_a = 0;
    chk("rr_recs", rid_a.size() - br, 5);
    for (int i = 0; i < 5 && br + i < rid_a.size(); i++) begin
      chk("rr_order", rid_a[br+i], i % 4);
      chk("rr_nomatch", rcnt_a[br+i], 0);
    end
    chk("ready_onehot", ready_bad, 0);

    // requester 2, three symbols, second matches
    bm = mpos_a.size(); br = rid_a.size(); k = clr_a;
    send(0, 2, 2'b01, 0); send(0, 2, 2'b11, 0); send(0, 2, 2'b10, 1);
    wait_rec(br + 1);
    chk("t1_clr_cycles", clr_a - k, 2);
    chk("t1_nmatch", mpos_a.size() - bm, 1);
    chk("t1_pos", mpos_a[bm], 2);
    chk("t1_id", mid_a[bm], 2);
    chk("t1_rec_id", rid_a[br], 2);
    chk("t1_rec_cnt", rcnt_a[br], 1);
    chk("t1_hold_id", match_id_a, 2);

    // 40-symbol record, matches on 18..22
    bm = mpos_a.size(); br = rid_a.size();
    for (int i = 1; i <= 40; i++) send(0, 0, (i >= 18 && i <= 22) ? 2'b11 : 2'b01, i == 40);
    wait_rec(br + 1);
    chk("t3_nmatch", mpos_a.size() - bm, 5);
    for (int i = 0; i < 5; i++) chk("t3_pos", mpos_a[bm+i], 18 + i);
    chk("t3_rec_id", rid_a[br], 0);
    chk("t3_rec_cnt", rcnt_a[br], 5);

    // bubbles: sym, gap, gap, matching last sym
    bm = mpos_a.size(); br = rid_a.size();
    send(0, 1, 2'b01, 0);
    chk("t4_eng_s1", {eng_i_a, eng_ic_a}, 2'b01);
    @(negedge clk);
    chk("t4_bubble1", {eng_i_a, eng_ic_a}, 2'b00);
    @(negedge clk);
    chk("t4_bubble2", {eng_i_a, eng_ic_a}, 2'b00);
    chk("t4_ready", req_ready_a, 4'b0010);
    send(0, 1, 2'b11, 1);
    chk("t4_eng_s2", {eng_i_a, eng_ic_a}, 2'b11);
    wait_rec(br + 1);
    chk("t4_nmatch", mpos_a.size() - bm, 1);
    chk("t4_pos", mpos_a[bm], 2);
    chk("t4_rec_cnt", rcnt_a[br], 1);

    // ENG_LAT=3: match on last symbol precedes rec_done
    send(1, 3, 2'b01, 0); send(1, 3, 2'b01, 0); send(1, 3, 2'b01, 0); send(1, 3, 2'b11, 1);
    k = 0;
    while (db_n < 1 && k < 500) begin @(negedge clk); k++; end
    chk("t5_done", db_n, 1);
    chk("t5_pos", mb_pos, 4);
    chk("t5_id", mb_id, 3);
    chk("t5_rec_cnt", db_cnt, 1);
    chk("t5_order", 32'(db_cyc > mb_cyc), 1);

    // reset mid-STREAM abandons the record
    send(0, 0, 2'b01, 0); send(0, 0, 2'b01, 0); send(0, 0, 2'b01, 0);
    chk("t6_streaming", {busy_a, req_ready_a}, 5'b10001);
    br = rid_a.size(); bm = mpos_a.size();
    reset_n = 0;
    #1;
    chk("t6_ready", req_ready_a, 0);
    chk("t6_eng_clr", eng_clr_a, 1);
    chk("t6_busy", busy_a, 0);
    chk("t6_rec_out", {rec_id_a, rec_matches_a}, 0);
    @(negedge clk);
    reset_n = 1;
    repeat (5) @(negedge clk);
    chk("t6_no_done", rid_a.size(), br);
    send(0, 0, 2'b11, 1);
    wait_rec(br + 1);
    chk("t6_pos_restart", mpos_a.size() > bm ? mpos_a[bm] : 0, 1);
    chk("t6_rec_cnt", rcnt_a[br], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
